// File: rtl/result_demux1to4by32_pkg.sv
// Shared destination codes and sizing for the result demux and its holding slots.
`ifndef RESULT_DEMUX1TO4BY32_PKG_SV
`define RESULT_DEMUX1TO4BY32_PKG_SV
package result_demux1to4by32_pkg;

    localparam int DEMUX_NUM_OUT = 4;
    localparam int DEMUX_ADDR_W  = 2;

    typedef enum logic [DEMUX_ADDR_W-1:0] {
        DEST_GPR  = 2'd0,
        DEST_FPR  = 2'd1,
        DEST_HILO = 2'd2,
        DEST_FCSR = 2'd3
    } dest_e;

endpackage
`endif

// File: rtl/result_demux1to4by32_hold_slot.sv
// One-entry valid/data holding register; loads 1 cycle after accept.
// Refill wins over drain in the same cycle, so a slot can stream 1 word/cycle.
module demux_hold_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (drain) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/result_demux1to4by32.sv
// Buffered 1-to-4 result demux (GPR/FPR/HILO/FCSR); 1-cycle accept-to-valid latency.
// in_ready stalls only the address whose slot is full and not draining; RESULT_DEMUX_PERF_CNT_EN adds perf_cnt.
module result_demux1to4by32
    import result_demux1to4by32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DEMUX_ADDR_W-1:0]  in_addr,
    input  logic [WIDTH-1:0]         in_data,
    output logic [DEMUX_NUM_OUT-1:0] out_valid,
    input  logic [DEMUX_NUM_OUT-1:0] out_ready,
    output logic [WIDTH-1:0]         out_data0,
    output logic [WIDTH-1:0]         out_data1,
    output logic [WIDTH-1:0]         out_data2,
    output logic [WIDTH-1:0]         out_data3
`ifdef RESULT_DEMUX_PERF_CNT_EN
    ,
    output logic [DEMUX_NUM_OUT*CNT_W-1:0] perf_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic                     accept;
    logic [DEMUX_NUM_OUT-1:0] load;
    logic [DEMUX_NUM_OUT-1:0] drain;
    logic [WIDTH-1:0]         slot_dout [DEMUX_NUM_OUT];

    assign in_ready = !out_valid[in_addr] || out_ready[in_addr];
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid & out_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < DEMUX_NUM_OUT; k++) begin
            load[k] = accept && (in_addr == DEMUX_ADDR_W'(k));
        end
    end

    for (genvar k = 0; k < DEMUX_NUM_OUT; k++) begin : g_slot
        demux_hold_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (load[k]),
            .drain   (drain[k]),
            .din     (in_data),
            .valid   (out_valid[k]),
            .dout    (slot_dout[k])
        );
    end

    assign out_data0 = slot_dout[DEST_GPR];
    assign out_data1 = slot_dout[DEST_FPR];
    assign out_data2 = slot_dout[DEST_HILO];
    assign out_data3 = slot_dout[DEST_FCSR];

`ifdef RESULT_DEMUX_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q [DEMUX_NUM_OUT];
    logic [CNT_W-1:0] cnt_d [DEMUX_NUM_OUT];

    // Saturate rather than wrap so a long run never reads as a small count.
    always_comb begin
        for (int k = 0; k < DEMUX_NUM_OUT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (load[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < DEMUX_NUM_OUT; k++) begin
            if (!reset_n) begin
                cnt_q[k] <= '0;
            end else begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    for (genvar k = 0; k < DEMUX_NUM_OUT; k++) begin : g_perf
        assign perf_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
`endif

endmodule

// File: doc/result_demux1to4by32.md
Name: result_demux1to4by32

Overview:
- Buffered 1-to-4 demultiplexer. It is the distribution counterpart of the 4-to-1 source-select muxes in the FPU/MIPS datapath.
- It accepts one result word tagged with a 2-bit destination address and steers it into one of four per-destination holding slots. Destinations are GPR write-back, FPR write-back, HI/LO and FCSR.
- Valid/ready handshake on the input and on each output. Each output slot holds its data until that destination consumes it, so a stalled destination back-pressures only traffic addressed to it.

Parameters:
- WIDTH, 32, data width of the input and of every output channel.
- CNT_W, 16, width of each transfer counter (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active-low. Sampled on rising clk only.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block will accept the presented word this cycle.
- in_addr  input  2  destination select: 0=GPR, 1=FPR, 2=HILO, 3=FCSR.
- in_data  input  WIDTH  result word.
- out_valid  output  4  bit k: slot k holds a word.
- out_ready  input  4  bit k: destination k consumes slot k this cycle.
- out_data0..out_data3  output  WIDTH each  contents of slots 0..3.
- perf_cnt  output  4*CNT_W  present only with RESULT_DEMUX_PERF_CNT_EN. Channel k occupies bits [k*CNT_W +: CNT_W].

Behaviour:
- Reset (reset_n=0 at a rising clk):
  - out_valid=4'b0000.
  - out_data0..3 = 0.
  - Counters = 0.
  - Reset mid-operation discards every held word; there is no partial delivery.
- in_ready is combinational: in_ready = !out_valid[in_addr] || out_ready[in_addr]. It depends on in_addr only and is independent of in_valid.
- Accept: in_valid && in_ready at a rising clk. Slot[in_addr] loads in_data and its out_valid is set. Latency is 1 cycle from accept to out_valid high.
- Drain: out_valid[k] && out_ready[k] at a rising clk clears out_valid[k], unless slot k is being refilled in the same cycle.
- Simultaneous drain and fill on the same slot: the new word is loaded and out_valid[k] stays 1. This gives back-to-back full throughput of 1 word/cycle.
- Drain on slot j while filling slot k (j≠k): both happen independently in the same cycle.
- Full slot with out_ready low: in_ready=0 for that address only. in_data and in_addr must be held by the producer until accepted. Other addresses still see in_ready=1 when their slots are free.
- Held slot data is stable while out_valid=1 and out_ready=0. It does not change with in_data.
- out_ready asserted on an empty slot has no effect.
- When out_valid[k]=0, out_data k retains its last loaded value; it is not zeroed.
- One input word per cycle maximum. There is no broadcast.

Optional Feature:
- Macro RESULT_DEMUX_PERF_CNT_EN.
- Defined:
  - Four CNT_W-bit counters. Counter k increments on each accept addressed to k.
  - Counters saturate at all-ones and do not wrap.
  - Reset clears them.
  - Values are exposed on perf_cnt.
- Undefined: counters and the perf_cnt port are absent. The rest of the behaviour is identical.

Decomposition:
- Shared package/header (guarded include):
  - DEMUX_NUM_OUT=4 and DEMUX_ADDR_W=2.
  - Destination codes DEST_GPR=0, DEST_FPR=1, DEST_HILO=2, DEST_FCSR=3.
- One sub-module, demux_hold_slot:
  - One-entry valid/data holding register, parameterised by WIDTH.
  - Inputs: clk, reset_n, load, drain, din. Outputs: valid, dout.
  - Instantiated four times. The top level does the address decode, generates in_ready, and contains the optional counters.

Test Plan:
- Reset, then in_valid=1, in_addr=2, in_data=32'h3F800000, out_ready=0 → next cycle out_valid=4'b0100, out_data2=32'h3F800000. Afterwards in_ready=0 for addr 2 and in_ready=1 for addr 0.
- Slot 1 full with out_ready[1]=1, and a new word 32'hDEADBEEF to addr 1 in the same cycle → out_valid[1] stays 1 and out_data1=32'hDEADBEEF. Five consecutive words to addr 1 with out_ready[1]=1 give 5 accepts in 5 cycles.
- Slot 0 stalled (out_ready[0]=0, holding 32'h1) while words to addr 3 stream in → addr 3 accepts every cycle. out_data0 stays 32'h1 throughout.
- All four slots filled with 32'hA0..A3, then reset_n=0 for one cycle → out_valid=0 and in_ready=1 for all addresses. No stale word is later delivered.
- With RESULT_DEMUX_PERF_CNT_EN and CNT_W=4: 17 accepts to addr 0 → perf_cnt[3:0]=4'hF (saturated) and other counters 0. Without the macro the design builds with no perf_cnt port.
